key_event_arbiter: RTL and testbench

//  Collects debounced key events from NUM_KEYS key_filter instances (1-cycle key_flag + key_state).

---
 rtl/key_evt_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/key_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_key_event_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Purpose: shared event encodings and key level constant for the key event path.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    // key_filter reports a held-down key as a low level
    localparam logic KEY_PRESSED = 1'b0;

    // Event type for a debounced edge, decided by the level after the edge
    function automatic logic [1:0] edge_type(input logic level);
        return (level == KEY_PRESSED) ? EVT_PRESS : EVT_RELEASE;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick among N requesters, search starts after last_grant and wraps.
// Latency: combinational; the pointer register lives with the caller and moves only on a grant.
// Backpressure: en=0 suppresses any grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    input  logic                 en,
    output logic                 grant_vld,
    output logic [$clog2(N)-1:0] grant_idx
);

    // First requester at or after last_grant+1, wrapping modulo N
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (en && !grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ($clog2(N))'(idx);
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Purpose: one-deep pending slot per key, round-robin merge into a registered valid/ready event stream; optional LONG events under KEY_LONG_PRESS_EN.
// Latency: key_flag at t -> evt_valid at t+2 when the output is free; one event per cycle while evt_ready=1.
// Backpressure: output held stable while evt_valid & !evt_ready; a new event on a still-pending key is dropped and sets sticky overflow.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_KEYS-1:0]         key_flag,
    input  logic [NUM_KEYS-1:0]         key_state,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_id,
    output logic [1:0]                  evt_type,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int IW = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] pending;
    logic [1:0]          pend_type [NUM_KEYS];
    logic [IW-1:0]       last_grant;
    logic                out_free;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx;
    logic [NUM_KEYS-1:0] granted;
    logic [NUM_KEYS-1:0] new_evt;
    logic [NUM_KEYS-1:0] drop;
    logic [1:0]          new_type  [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_fire;

    assign out_free = !evt_valid || evt_ready;

    rr_arbiter #(.N(NUM_KEYS)) u_rr (
        .req        (pending),
        .last_grant (last_grant),
        .en         (out_free),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    // Per-key event source, type and drop decision; an edge outranks a LONG in the same cycle
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            granted[i]  = grant_vld && (grant_idx == IW'(i));
            new_evt[i]  = key_flag[i] || long_fire[i];
            new_type[i] = key_flag[i] ? edge_type(key_state[i]) : EVT_LONG;
            drop[i]     = new_evt[i] && pending[i] && !granted[i];
        end
    end

    // Pending slots: a slot leaving this cycle can take a new event, an occupied one keeps its old event
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pending <= '0;
            for (int i = 0; i < NUM_KEYS; i++) pend_type[i] <= EVT_PRESS;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (new_evt[i] && (granted[i] || !pending[i])) begin
                    pending[i]   <= 1'b1;
                    pend_type[i] <= new_type[i];
                end else if (granted[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Output register and RR pointer; both only move when the output slot is free
    always_ff @(posedge Clk) begin
        if (Rst) begin
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_type   <= EVT_PRESS;
            last_grant <= IW'(NUM_KEYS - 1);
        end else if (out_free) begin
            evt_valid <= grant_vld;
            if (grant_vld) begin
                evt_id     <= grant_idx;
                evt_type   <= pend_type[grant_idx];
                last_grant <= grant_idx;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge Clk) begin
        if (Rst)          overflow <= 1'b0;
        else if (|drop)   overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = $clog2(TICK_DIV + 1);
    localparam int CW       = $clog2(LONG_PRESS_MS + 1);

    logic [PW-1:0]       presc;
    logic                ms_tick;
    logic [CW-1:0]       ms_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] armed;

    assign ms_tick = (presc == PW'(TICK_DIV - 1));

    // Free-running 1 ms prescaler
    always_ff @(posedge Clk) begin
        if (Rst)          presc <= '0;
        else if (ms_tick) presc <= '0;
        else              presc <= presc + 1'b1;
    end

    // LONG fires on the tick that completes the hold time of an armed, still-pressed key
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            long_fire[i] = armed[i] && ms_tick && (key_state[i] == KEY_PRESSED) && !key_flag[i]
                           && (ms_cnt[i] == CW'(LONG_PRESS_MS - 1));
        end
    end

    // Hold counters: a PRESS edge arms and clears, a RELEASE edge disarms, firing disarms so one LONG per press
    always_ff @(posedge Clk) begin
        if (Rst) begin
            armed <= '0;
            for (int i = 0; i < NUM_KEYS; i++) ms_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_flag[i]) begin
                    armed[i]  <= (key_state[i] == KEY_PRESSED);
                    ms_cnt[i] <= '0;
                end else if (armed[i] && ms_tick && (key_state[i] == KEY_PRESSED)) begin
                    ms_cnt[i] <= ms_cnt[i] + 1'b1;
                    if (long_fire[i]) armed[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign long_fire = '0;

    // Timing parameters only matter to the long-press build
    logic unused_cfg;
    assign unused_cfg = ^{CLK_FREQ_HZ, LONG_PRESS_MS};
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;
    import key_evt_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] key_flag;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    key_event_arbiter #(
        .NUM_KEYS      (4),
        .CLK_FREQ_HZ   (1000),
        .LONG_PRESS_MS (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .key_flag  (key_flag),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] flag;
        logic [3:0] state;
        logic       ready;
        logic       clr;
        logic       rst;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [1:0] exp_type;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] f, input logic [3:0] s, input logic rd, input logic cl,
                       input logic rs, input logic ev, input logic [1:0] ei, input logic [1:0] et,
                       input logic eo);
        vec_t v;
        v.flag = f; v.state = s; v.ready = rd; v.clr = cl; v.rst = rs;
        v.exp_valid = ev; v.exp_id = ei; v.exp_type = et; v.exp_ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct { logic [1:0] id; logic [1:0] typ; } evt_t;
    evt_t got[$];
    evt_t exp_q[$];

    initial begin
        Rst = 1'b1; key_flag = '0; key_state = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;

        //   flag    state  rdy  clr  rst | vld id     type         ovf
        // reset state
        add(4'h0, 4'hF, 1, 0, 1,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 1,   0, 2'd0, EVT_PRESS,   0);
        // single press on key 2, visible two cycles later for one cycle
        add(4'h4, 4'hB, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hB, 1, 0, 0,   1, 2'd2, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // fresh pointer, then simultaneous keys 0,1,3
        add(4'h0, 4'hF, 1, 0, 1,   0, 2'd0, EVT_PRESS,   0);
        add(4'hB, 4'h0, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd1, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd3, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // second burst after pointer wrap starts at key 0 again
        add(4'hB, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd0, EVT_RELEASE, 0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd1, EVT_RELEASE, 0);
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd3, EVT_RELEASE, 0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // backpressure: key 1 held for 10 cycles, accepted once
        add(4'h2, 4'hF, 0, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        for (int i = 0; i < 10; i++) add(4'h0, 4'hF, 0, 0, 0, 1, 2'd1, EVT_RELEASE, 0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // overflow: key 0 parked on the output, key 1 flagged twice
        add(4'h1, 4'hE, 0, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 0, 0, 0,   1, 2'd0, EVT_PRESS,   0);
        add(4'h2, 4'hF, 0, 0, 0,   1, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 0, 0, 0,   1, 2'd0, EVT_PRESS,   0);
        add(4'h0, 4'hF, 0, 0, 0,   1, 2'd0, EVT_PRESS,   0);
        add(4'h2, 4'hF, 0, 0, 0,   1, 2'd0, EVT_PRESS,   1);
        add(4'h0, 4'hF, 0, 1, 0,   1, 2'd0, EVT_PRESS,   0);
        // drop in the same cycle as clear wins
        add(4'h2, 4'hF, 0, 1, 0,   1, 2'd0, EVT_PRESS,   1);
        add(4'h0, 4'hF, 0, 1, 0,   1, 2'd0, EVT_PRESS,   0);
        // drain: the first (kept) key 1 event comes out
        add(4'h0, 4'hF, 1, 0, 0,   1, 2'd1, EVT_RELEASE, 0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // new flag on a key being granted is captured, not dropped
        add(4'h2, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h2, 4'hD, 1, 0, 0,   1, 2'd1, EVT_RELEASE, 0);
        add(4'h0, 4'hD, 1, 0, 0,   1, 2'd1, EVT_PRESS,   0);
        add(4'h0, 4'hF, 1, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        // reset mid-stream with keys pending and an event presented
        add(4'h7, 4'hF, 0, 0, 0,   0, 2'd0, EVT_PRESS,   0);
        add(4'h8, 4'hF, 0, 0, 0,   1, 2'd2, EVT_RELEASE, 0);
        add(4'h1, 4'hF, 0, 0, 0,   1, 2'd2, EVT_RELEASE, 1);
        add(4'h0, 4'hF, 1, 0, 1,   0, 2'd0, EVT_PRESS,   0);
        for (int i = 0; i < 4; i++) add(4'h0, 4'hF, 1, 0, 0, 0, 2'd0, EVT_PRESS, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            key_flag  = tbl[r].flag;
            key_state = tbl[r].state;
            evt_ready = tbl[r].ready;
            ovf_clr   = tbl[r].clr;
            Rst       = tbl[r].rst;
            step();
            check($sformatf("row%0d evt_valid", r), 32'(evt_valid), 32'(tbl[r].exp_valid));
            check($sformatf("row%0d overflow", r), 32'(overflow), 32'(tbl[r].exp_ovf));
            if (tbl[r].exp_valid || tbl[r].rst) begin
                check($sformatf("row%0d evt_id", r), 32'(evt_id), 32'(tbl[r].exp_id));
                check($sformatf("row%0d evt_type", r), 32'(evt_type), 32'(tbl[r].exp_type));
            end
        end

        // Long hold on key 3: PRESS, optional LONG, RELEASE, collected from the stream
        Rst = 1'b1; key_flag = '0; key_state = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;
        step();
        Rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                key_flag = 4'h8; key_state = 4'h7;
            end else if (c <= 5) begin
                key_flag = 4'h0; key_state = 4'h7;
            end else if (c == 6) begin
                key_flag = 4'h8; key_state = 4'hF;
            end else begin
                key_flag = 4'h0; key_state = 4'hF;
            end
            step();
            if (evt_valid) got.push_back('{id: evt_id, typ: evt_type});
        end

        exp_q.push_back('{id: 2'd3, typ: EVT_PRESS});
`ifdef KEY_LONG_PRESS_EN
        exp_q.push_back('{id: 2'd3, typ: EVT_LONG});
`endif
        exp_q.push_back('{id: 2'd3, typ: EVT_RELEASE});

        check("hold event count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                check($sformatf("hold evt%0d id", i), 32'(got[i].id), 32'(exp_q[i].id));
                check($sformatf("hold evt%0d type", i), 32'(got[i].typ), 32'(exp_q[i].typ));
            end else begin
                check($sformatf("hold evt%0d missing", i), 32'(0), 32'(1));
            end
        end
        check("hold overflow", 32'(overflow), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
